// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake and holds the word for decode.
// Optional bus-error trapping into a sticky FAULT state is enabled by defining FETCH_ERR_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        advance,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic        fetch_fault
);

`ifdef FETCH_ERR_EN
  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_e;
`else
  typedef enum logic {FETCH, HOLD} state_e;
  logic unused_imem_err;
  assign unused_imem_err = imem_err;
`endif

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // jump outranks branch; both only matter in the advance cycle
  always_comb begin
    if (jump)                next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (branch && zero) next_pc = pc_plus4 + br_off;
    else                     next_pc = pc_plus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
`ifdef FETCH_ERR_EN
          if (imem_err) begin
            state_d = FAULT;
          end else begin
            state_d = HOLD;
            instr_d = imem_rdata;
          end
`else
          state_d = HOLD;
          instr_d = imem_rdata;
`endif
        end
      end
      HOLD: begin
        if (advance) begin
          state_d = FETCH;
          pc_d    = next_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_AL;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // request is gated by reset so an abandoned fetch drops without waiting for a clock
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = (state_q == HOLD);
`ifdef FETCH_ERR_EN
  assign fetch_fault = (state_q == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed PC scenarios plus randomized traffic against a next-PC model.
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        advance, branch, jump, zero;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  opcode;
  logic        instr_valid, fetch_fault;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .advance(advance), .branch(branch), .jump(jump), .zero(zero),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit br, input bit jp, input bit z);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && z) return seq + 32'($signed(w[15:0])) * 32'd4;
    return seq;
  endfunction

  // Called at a negedge with the DUT in FETCH at m_pc; leaves it in FETCH at the new m_pc.
  task automatic run_instr(input logic [31:0] w, input bit br, input bit jp, input bit z,
                           input int stall, input int hold);
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_fetch: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                 imem_req, imem_addr, instr_valid, m_pc);
      end
      imem_ready = 1'b0;
      advance = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    advance = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
               imem_req, imem_addr, instr_valid, m_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    m_instr = w;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== w || opcode !== w[31:26] || pc !== m_pc || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold: valid=%b instr=%h op=%h pc=%h req=%b, expected valid=1 instr=%h op=%h pc=%h req=0",
                 instr_valid, instr, opcode, pc, imem_req, w, w[31:26], m_pc);
      end
      if (i < hold) begin
        advance = 1'b0;
        branch = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        @(negedge clk);
      end
    end
    advance = 1'b1; branch = br; jump = jp; zero = z; imem_ready = 1'b0;
    @(negedge clk);
    advance = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    m_pc = model_next(m_pc, w, br, jp, z);
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
      failures++;
      $display("FAIL next_pc: req=%b valid=%b pc=%h addr=%h pc4=%h, expected req=1 valid=0 pc=%h",
               imem_req, instr_valid, pc, imem_addr, pc_plus4, m_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ready = 1'b0; imem_err = 1'b0; imem_rdata = 32'd0;
    advance = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc !== RPC || instr !== 32'd0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b pc=%h instr=%h valid=%b fault=%b, expected 0/%h/0/0/0",
               imem_req, pc, instr, instr_valid, fetch_fault, RPC);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    m_pc = RPC;
  endtask

  task automatic test_sequential();
    run_instr(32'h8C22_0004, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (imem_addr !== 32'h44) begin
      failures++;
      $display("FAIL seq_0x44: addr=%h, expected 00000044", imem_addr);
    end
    for (int i = 0; i < 4; i++)
      run_instr($urandom, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_branch();
    run_instr({6'h02, 26'h000_0040}, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 1'b0, 1'b0, 0, 0);
    checks++;
    if (pc !== 32'h104) begin
      failures++;
      $display("FAIL branch_not_taken: pc=%h, expected 00000104", pc);
    end
    run_instr({6'h02, 26'h000_0040}, 1'b0, 1'b1, 1'b0, 1, 0);
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 1'b0, 1'b1, 0, 0);
    checks++;
    if (pc !== 32'hFC) begin
      failures++;
      $display("FAIL branch_taken: pc=%h, expected 000000fc", pc);
    end
  endtask

  task automatic test_wrap();
    // backward branch from 0xFC that lands below zero
    run_instr({6'h04, 5'd3, 5'd3, 16'hFFBF}, 1'b1, 1'b0, 1'b1, 0, 0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL branch_wrap: pc=%h, expected fffffffc", pc);
    end
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 1);
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL seq_wrap: addr=%h, expected 00000000", imem_addr);
    end
  endtask

  task automatic test_jump_priority();
    run_instr({6'h02, 26'h000_0100}, 1'b1, 1'b1, 1'b1, 0, 0);
    checks++;
    if (pc !== 32'h400) begin
      failures++;
      $display("FAIL jump_priority: pc=%h, expected 00000400", pc);
    end
  endtask

  task automatic test_stall_reset();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      advance = 1'b1;
      @(negedge clk);
    end
    advance = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== RPC || instr_valid !== 1'b0 || instr !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: req=%b pc=%h valid=%b instr=%h, expected 0/%h/0/0",
               imem_req, pc, instr_valid, instr, RPC);
    end
    @(negedge clk);
    reset = 1'b0;
    m_pc = RPC;
    @(negedge clk);
    run_instr($urandom, 1'b0, 1'b0, 1'b0, 5, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_instr($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 2));
  endtask

  task automatic test_fault();
    logic [31:0] w;
    w = $urandom;
    imem_ready = 1'b1; imem_err = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ready = 1'b0; imem_err = 1'b0;
`ifdef FETCH_ERR_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== m_instr) begin
        failures++;
        $display("FAIL fault_sticky: fault=%b req=%b valid=%b instr=%h, expected 1/0/0/%h",
                 fetch_fault, imem_req, instr_valid, instr, m_instr);
      end
      advance = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    advance = 1'b0; imem_ready = 1'b0;
`else
    checks++;
    if (fetch_fault !== 1'b0 || instr_valid !== 1'b1 || instr !== w || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL err_ignored: fault=%b valid=%b instr=%h req=%b, expected 0/1/%h/0",
               fetch_fault, instr_valid, instr, imem_req, w);
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
      failures++;
      $display("FAIL fault_cleared: fault=%b req=%b addr=%h, expected 0/1/%h",
               fetch_fault, imem_req, imem_addr, RPC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_jump_priority();
    test_stall_reset();
    test_random();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
